// File: rtl/gray_pkg.sv
// Shared definitions for the binary/Gray converter.
// Provides the default code width, the conversion-direction enum and reference
// conversion helpers. The helpers work on GRAY_W_MAX-bit words. Narrower
// operands are zero-extended first, and the leading zeros do not change the
// result.
package gray_pkg;

    localparam int GRAY_W_DEFAULT = 4;
    localparam int GRAY_W_MAX     = 32;

    typedef enum logic {
        DIR_B2G = 1'b0,
        DIR_G2B = 1'b1
    } dir_e;

    function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
        logic [GRAY_W_MAX-1:0] b;
        b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
        for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // A value with exactly one bit set is non-zero and has no bit left after
    // its lowest set bit is cleared.
    function automatic logic popcount_is_one(input logic [GRAY_W_MAX-1:0] x);
        return (x != '0) && ((x & (x - GRAY_W_MAX'(1))) == '0);
    endfunction

endpackage

// File: rtl/day_9_binary_to_gray_code_if.sv
// Data/strobe bundle for the binary/Gray converter.
// Signal names are given from the converter's point of view.
//   valid_i : qualifies dir_i/bin_i
//   dir_i   : 0 = binary->Gray, 1 = Gray->binary
//   bin_i   : input word
//   gray_o  : registered converted word
//   valid_o : gray_o updated this cycle
//   adj_o   : consecutive encodes differ by exactly one bit
// slave  : the converter
// master : the producer/consumer driving it
interface day_9_binary_to_gray_code_if #(
    parameter int WIDTH = 4
);
    logic             valid_i;
    logic             dir_i;
    logic [WIDTH-1:0] bin_i;
    logic [WIDTH-1:0] gray_o;
    logic             valid_o;
    logic             adj_o;

    modport slave (
        input  valid_i, dir_i, bin_i,
        output gray_o, valid_o, adj_o
    );

    modport master (
        output valid_i, dir_i, bin_i,
        input  gray_o, valid_o, adj_o
    );
endinterface

// File: rtl/gray_to_bin_prefix.sv
// Combinational Gray-to-binary decoder.
//   gray_i : WIDTH-bit reflected Gray word
//   bin_o  : WIDTH-bit binary word
// Each binary bit is the XOR of all Gray bits at or above its position.
// Each bit is computed from its own slice of gray_i, not by chaining through
// the neighbouring output bit. This gives the same prefix-XOR result without
// a self-referencing vector.
module gray_to_bin_prefix #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[WIDTH-1:i];
    end

endmodule

// File: rtl/day_9_binary_to_gray_code.sv
// Registered binary<->Gray converter with a one-bit adjacency checker.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : slave side of day_9_binary_to_gray_code_if
//            (valid_i, dir_i, bin_i in; gray_o, valid_o, adj_o out)
// Latency is one cycle, and the converter accepts one word per cycle.
// Only encoded words take part in the adjacency history. Decoded words
// always report adj_o=0 and do not change that history.
// The supported range of WIDTH is 2 to GRAY_W_MAX.
module day_9_binary_to_gray_code
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_W_DEFAULT
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    day_9_binary_to_gray_code_if.slave      bus
);

    logic [WIDTH-1:0] gray_enc;
    logic [WIDTH-1:0] bin_dec;

    logic [WIDTH-1:0] gray_q, gray_d;
    logic [WIDTH-1:0] last_gray_q, last_gray_d;
    logic             valid_q, valid_d;
    logic             adj_q, adj_d;
    logic             first_q, first_d;

    assign gray_enc = WIDTH'(bin2gray(GRAY_W_MAX'(bus.bin_i)));

    gray_to_bin_prefix #(
        .WIDTH (WIDTH)
    ) u_dec (
        .gray_i (bus.bin_i),
        .bin_o  (bin_dec)
    );

    always_comb begin
        gray_d      = gray_q;
        last_gray_d = last_gray_q;
        valid_d     = 1'b0;
        adj_d       = adj_q;
        first_d     = first_q;
        if (bus.valid_i) begin
            valid_d = 1'b1;
            if (bus.dir_i == DIR_B2G) begin
                gray_d      = gray_enc;
                // There is no previous encode to compare against right after reset.
                adj_d       = !first_q &&
                              popcount_is_one(GRAY_W_MAX'(gray_enc ^ last_gray_q));
                last_gray_d = gray_enc;
                first_d     = 1'b0;
            end else begin
                gray_d = bin_dec;
                adj_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gray_q      <= '0;
            last_gray_q <= '0;
            valid_q     <= 1'b0;
            adj_q       <= 1'b0;
            first_q     <= 1'b1;
        end else begin
            gray_q      <= gray_d;
            last_gray_q <= last_gray_d;
            valid_q     <= valid_d;
            adj_q       <= adj_d;
            first_q     <= first_d;
        end
    end

    assign bus.gray_o  = gray_q;
    assign bus.valid_o = valid_q;
    assign bus.adj_o   = adj_q;

endmodule

// File: tb/tb_day_9_binary_to_gray_code.sv
// Self-checking bench for day_9_binary_to_gray_code.
// Runs a WIDTH=4 and a WIDTH=8 instance side by side. A behavioural model
// predicts the outputs: Gray values come from arithmetic, binary values from
// searching for the preimage, and adjacency from a bit count.
module tb_day_9_binary_to_gray_code;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    day_9_binary_to_gray_code_if #(.WIDTH(4)) bus4 ();
    day_9_binary_to_gray_code_if #(.WIDTH(8)) bus8 ();

    day_9_binary_to_gray_code #(.WIDTH(4)) dut4 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus4.slave)
    );

    day_9_binary_to_gray_code #(.WIDTH(8)) dut8 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus8.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Model state; index 0 = WIDTH 4, index 1 = WIDTH 8.
    int m_gray  [2];
    int m_last  [2];
    bit m_valid [2];
    bit m_adj   [2];
    bit m_first [2];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int enc(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int dec(input int g, input int w);
        for (int v = 0; v < (1 << w); v++) begin
            if (enc(v) == g) return v;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_gray[k]  = 0;
            m_last[k]  = 0;
            m_valid[k] = 0;
            m_adj[k]   = 0;
            m_first[k] = 1;
        end
    endtask

    task automatic model_step(input int k, input int w, input bit v, input bit d, input int b);
        int g;
        m_valid[k] = v;
        if (v) begin
            if (!d) begin
                g          = enc(b);
                m_adj[k]   = !m_first[k] && ($countones(g ^ m_last[k]) == 1);
                m_last[k]  = g;
                m_first[k] = 0;
                m_gray[k]  = g;
            end else begin
                m_gray[k] = dec(b, w);
                m_adj[k]  = 0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, " gray4"},  int'(bus4.gray_o),  m_gray[0]);
        chk({tag, " valid4"}, int'(bus4.valid_o), int'(m_valid[0]));
        chk({tag, " adj4"},   int'(bus4.adj_o),   int'(m_adj[0]));
        chk({tag, " gray8"},  int'(bus8.gray_o),  m_gray[1]);
        chk({tag, " valid8"}, int'(bus8.valid_o), int'(m_valid[1]));
        chk({tag, " adj8"},   int'(bus8.adj_o),   int'(m_adj[1]));
    endtask

    task automatic step(input string tag,
                        input bit v4, input bit d4, input int b4,
                        input bit v8, input bit d8, input int b8);
        @(negedge clk);
        bus4.valid_i = v4;
        bus4.dir_i   = d4;
        bus4.bin_i   = 4'(b4);
        bus8.valid_i = v8;
        bus8.dir_i   = d8;
        bus8.bin_i   = 8'(b8);
        @(posedge clk);
        model_step(0, 4, v4, d4, b4 & 'hF);
        model_step(1, 8, v8, d8, b8 & 'hFF);
        #1;
        check_outputs(tag);
    endtask

    task automatic step4(input string tag, input bit v, input bit d, input int b);
        step(tag, v, d, b, 1'($urandom), 1'($urandom), int'($urandom_range(0, 255)));
    endtask

    int sweep_exp [16] = '{'h0, 'h1, 'h3, 'h2, 'h6, 'h7, 'h5, 'h4,
                           'hC, 'hD, 'hF, 'hE, 'hA, 'hB, 'h9, 'h8};

    initial begin
        bus4.valid_i = 0; bus4.dir_i = 0; bus4.bin_i = '0;
        bus8.valid_i = 0; bus8.dir_i = 0; bus8.bin_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Sweep 0..15 encode
        for (int i = 0; i < 16; i++) begin
            step4("sweep", 1, 0, i);
            chk("sweep_seq", int'(bus4.gray_o), sweep_exp[i]);
            chk("sweep_adj", int'(bus4.adj_o), (i == 0) ? 0 : 1);
        end

        // Wrap and repeat
        step4("wrap0", 1, 0, 'h0);
        chk("wrap_adj", int'(bus4.adj_o), 1);
        step4("repeat0", 1, 0, 'h0);
        chk("repeat_adj", int'(bus4.adj_o), 0);
        step4("jump5", 1, 0, 'h5);
        chk("jump_gray", int'(bus4.gray_o), 'h7);
        chk("jump_adj", int'(bus4.adj_o), 0);

        // Decode; the following encode still compares against gray 0x7
        step4("decB", 1, 1, 'hB);
        chk("decB_val", int'(bus4.gray_o), 'hD);
        step4("dec8", 1, 1, 'h8);
        chk("dec8_val", int'(bus4.gray_o), 'hF);
        step4("dec0", 1, 1, 'h0);
        chk("dec0_val", int'(bus4.gray_o), 'h0);
        step4("enc_after_dec", 1, 0, 'h4);
        chk("enc_after_dec_adj", int'(bus4.adj_o), 1);

        // Hold on invalid
        step4("enc6", 1, 0, 'h6);
        chk("enc6_gray", int'(bus4.gray_o), 'h5);
        for (int i = 0; i < 3; i++) begin
            step4("hold", 0, i[0], (i[0]) ? 'hA : 'h3);
            chk("hold_gray", int'(bus4.gray_o), 'h5);
            chk("hold_valid", int'(bus4.valid_o), 0);
        end

        // Async reset between edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        #1;
        rst_n = 1'b1;
        step4("post_rst", 1, 0, 'h1);
        chk("post_rst_gray", int'(bus4.gray_o), 'h1);
        chk("post_rst_adj", int'(bus4.adj_o), 0);

        // WIDTH=8 directed
        step("w8_ff", 1, 0, 0, 1, 0, 'hFF);
        chk("w8_ff_gray", int'(bus8.gray_o), 'h80);
        step("w8_80", 1, 0, 1, 1, 0, 'h80);
        chk("w8_80_gray", int'(bus8.gray_o), 'hC0);
        step("w8_dec80", 1, 1, 2, 1, 1, 'h80);
        chk("w8_dec80_val", int'(bus8.gray_o), 'hFF);

        // Random traffic, including increment runs that should flag adjacency
        for (int i = 0; i < 400; i++) begin
            if (i % 50 < 20)
                step("rand_inc", 1, 0, i, 1, 0, i);
            else
                step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom), int'($urandom_range(0, 15)),
                     1'($urandom_range(0, 3) != 0), 1'($urandom), int'($urandom_range(0, 255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/day_9_binary_to_gray_code.md
Name: day_9_binary_to_gray_code

Overview:
- Registered, parameterisable binary↔Gray code converter with a valid strobe.
- Primary mode: binary to reflected Gray. Secondary mode: Gray back to binary, so the same block serves encode and decode.
- Includes an adjacency checker that flags whether consecutive encoded outputs differ by exactly one bit.
- Sits between counters/pointers and consumers needing Gray-coded values (e.g. CDC pointer paths, encoders).

Parameters:
- WIDTH, 4, bit width of the input and output code words (legal ≥ 2).

Ports:
- clk_i  input  1  clock, rising-edge active.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  qualifies bin_i/dir_i this cycle.
- dir_i  input  1  0 = binary→Gray, 1 = Gray→binary.
- bin_i  input  WIDTH  input word: binary when dir_i=0, Gray when dir_i=1.
- gray_o  output  WIDTH  converted word, registered.
- valid_o  output  1  gray_o updated this cycle.
- adj_o  output  1  Gray adjacency flag, dir_i=0 results only.

Behaviour:
- Single clock domain. One clock; reset is asynchronous and active-low (clk_i, rst_ni).
- Reset (rst_ni=0, asserted at any time, takes effect immediately): gray_o=0, valid_o=0, adj_o=0, internal last-Gray register=0, first-flag=1.
- Latency: exactly 1 cycle. Inputs sampled on rising clk_i with valid_i=1 appear on gray_o/valid_o/adj_o after that edge. Full throughput, one word per cycle, no backpressure.
- Encode (dir_i=0): gray = bin ^ (bin >> 1). gray[WIDTH-1]=bin[WIDTH-1]; gray[i]=bin[i+1]^bin[i].
- Decode (dir_i=1): bin[WIDTH-1]=g[WIDTH-1]; bin[i]=bin[i+1]^g[i] for i from WIDTH-2 down to 0. This is a prefix-XOR, purely combinational before the output register.
- valid_i=0: gray_o and adj_o hold their last values; valid_o=0 next cycle.
- Adjacency (dir_i=0 accepted word):
  - adj_o = 1 iff popcount(new_gray ^ last_gray) == 1.
  - last_gray then updates to new_gray and first-flag clears.
  - On the first encode after reset, adj_o=0 regardless of value.
  - Repeated identical input gives adj_o=0.
- Adjacency (dir_i=1 accepted word): adj_o=0; last_gray and first-flag are unchanged.
- Wrap-around: encoding max (all ones) then 0 is a legal single-bit step. For WIDTH=4, 0x8→0x0 gives adj_o=1.
- All arithmetic is unsigned, WIDTH bits wide, with no truncation or extension.
- No X propagation: outputs are defined from reset onward.

Decomposition:
- Shared package gray_pkg:
  - constant GRAY_W_DEFAULT = 4.
  - enum dir_e {DIR_B2G=0, DIR_G2B=1}.
  - pure functions bin2gray(), gray2bin(), popcount_is_one().
- One natural sub-module: gray_to_bin_prefix, a combinational WIDTH-parameterised prefix-XOR decoder instantiated by the top.
- Encode, adjacency logic and output registers stay in the top.

Test Plan:
1. Reset, then sweep bin_i 0..15 with dir_i=0, valid_i=1 every cycle.
   - gray_o sequence, each one cycle after its input: 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8.
   - valid_o=1 throughout.
   - adj_o=0 on the first word, 1 on every later word.
2. Wrap and repeat, dir_i=0.
   - After 0xF (gray 0x8), apply 0x0: gray_o=0x0, adj_o=1.
   - Apply 0x0 again: adj_o=0.
   - Apply 0x5 directly after 0x0: gray_o=0x7, adj_o=0.
3. Decode, dir_i=1.
   - Gray 0xB → gray_o=0xD; 0x8 → 0xF; 0x0 → 0x0.
   - adj_o=0 throughout; a subsequent encode still compares against the prior encode's last_gray.
4. Hold on invalid.
   - Encode 0x6 (→0x5), then valid_i=0 for 3 cycles with bin_i toggling.
   - gray_o stays 0x5, valid_o=0 for those 3 cycles.
5. Async reset mid-stream.
   - Pulse rst_ni low between clock edges: gray_o, valid_o, adj_o go 0 immediately.
   - The next encode of 0x1 gives gray_o=0x1, adj_o=0 (first-flag set).
6. WIDTH=8 instance.
   - Encode 0xFF → 0x80; encode 0x80 → 0xC0.
   - Decode 0x80 → 0xFF.
